// File: rtl/sprite_ram_loader_pkg.sv
// Shared sprite definitions: loader FSM states, sprite geometry and the 2-bit palette code.
// The sprite source imports this package too, so the palette code type is defined only here.
package sprite_ram_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FILL  = 2'd2
  } loader_state_t;

  localparam int PIX_PER_WORD  = 16;
  localparam int SPRITE_PIXELS = 256;

  typedef logic [1:0] pal_code_t;

endpackage

// File: rtl/sprite_ram_loader.sv
// Unpacks 32-bit words into 2-bit pixel writes and fills whole 256-pixel sprite slots.
// One pixel write per clock. A fill request that arrives while busy is queued and runs at the next word boundary.
module sprite_ram_loader
  import sprite_ram_loader_pkg::*;
#(
  parameter int ADDR = 10,
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [ADDR-5:0] wr_addr,
  input  logic [WORD-1:0] wr_data,
  input  logic            clr_req,
  input  logic [ADDR-9:0] clr_sid,
  input  pal_code_t       clr_code,
  output logic            we,
  output logic [ADDR-1:0] addr_w,
  output pal_code_t       pixel_in,
  output logic            busy,
  output logic            done
);

  localparam logic [3:0] WORD_LAST = 4'(PIX_PER_WORD - 1);
  localparam logic [7:0] FILL_LAST = 8'(SPRITE_PIXELS - 1);

  loader_state_t   state_reg;
  logic [7:0]      cnt_reg;
  logic [WORD-1:0] hold_reg;
  logic [ADDR-5:0] word_addr_reg;
  logic [ADDR-9:0] fill_sid_reg;
  pal_code_t       fill_code_reg;
  logic            pend_reg;
  logic [ADDR-9:0] pend_sid_reg;
  pal_code_t       pend_code_reg;

  logic            start_fill;
  logic            load_word;
  logic            advance;
  logic            finish;
  logic [ADDR-9:0] sid_sel;
  pal_code_t       code_sel;

  assign wr_ready = (state_reg == ST_IDLE && !clr_req) ||
                    (state_reg == ST_SHIFT && cnt_reg[3:0] == WORD_LAST && !pend_reg);

  // A request arriving this very cycle is newer than the queued one, so it wins.
  assign sid_sel  = clr_req ? clr_sid  : pend_sid_reg;
  assign code_sel = clr_req ? clr_code : pend_code_reg;

  always_comb begin
    start_fill = 1'b0;
    load_word  = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        start_fill = clr_req;
        load_word  = !clr_req && wr_valid;
      end
      ST_SHIFT: begin
        if (cnt_reg[3:0] == WORD_LAST) begin
          finish     = 1'b1;
          start_fill = pend_reg || (clr_req && !wr_valid);
          load_word  = !pend_reg && wr_valid;
        end else begin
          advance = 1'b1;
        end
      end
      ST_FILL: begin
        if (cnt_reg == FILL_LAST) begin
          finish     = 1'b1;
          start_fill = pend_reg || clr_req;
        end else begin
          advance = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      hold_reg      <= '0;
      word_addr_reg <= '0;
      fill_sid_reg  <= '0;
      fill_code_reg <= '0;
      pend_reg      <= 1'b0;
      pend_sid_reg  <= '0;
      pend_code_reg <= '0;
      we            <= 1'b0;
      addr_w        <= '0;
      pixel_in      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= finish;

      if (start_fill) begin
        pend_reg <= 1'b0;
      end else if (clr_req && state_reg != ST_IDLE) begin
        pend_reg      <= 1'b1;
        pend_sid_reg  <= clr_sid;
        pend_code_reg <= clr_code;
      end

      if (start_fill) begin
        state_reg     <= ST_FILL;
        cnt_reg       <= '0;
        fill_sid_reg  <= sid_sel;
        fill_code_reg <= code_sel;
        we            <= 1'b1;
        addr_w        <= {sid_sel, 8'h00};
        pixel_in      <= code_sel;
        busy          <= 1'b1;
      end else if (load_word) begin
        // Pixel 0 goes straight to the outputs; the remaining pixels wait in hold_reg.
        state_reg     <= ST_SHIFT;
        cnt_reg       <= '0;
        word_addr_reg <= wr_addr;
        hold_reg      <= {2'b00, wr_data[WORD-1:2]};
        we            <= 1'b1;
        addr_w        <= {wr_addr, 4'h0};
        pixel_in      <= wr_data[1:0];
        busy          <= 1'b1;
      end else if (advance) begin
        cnt_reg <= cnt_reg + 8'd1;
        we      <= 1'b1;
        if (state_reg == ST_SHIFT) begin
          addr_w   <= {word_addr_reg, cnt_reg[3:0] + 4'd1};
          pixel_in <= hold_reg[1:0];
          hold_reg <= {2'b00, hold_reg[WORD-1:2]};
        end else begin
          addr_w   <= {fill_sid_reg, cnt_reg + 8'd1};
          pixel_in <= fill_code_reg;
        end
      end else begin
        state_reg <= ST_IDLE;
        cnt_reg   <= '0;
        we        <= 1'b0;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed bench for sprite_ram_loader: a monitor logs every RAM write, and each scenario compares the log against hand-derived addresses and data.
module tb_sprite_ram_loader;

  logic       clk;
  logic       reset_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [5:0] wr_addr;
  logic [31:0] wr_data;
  logic       clr_req;
  logic [1:0] clr_sid;
  logic [1:0] clr_code;
  logic       we;
  logic [9:0] addr_w;
  logic [1:0] pixel_in;
  logic       busy;
  logic       done;

  sprite_ram_loader #(.ADDR(10), .WORD(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .clr_sid  (clr_sid),
    .clr_code (clr_code),
    .we       (we),
    .addr_w   (addr_w),
    .pixel_in (pixel_in),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int unsigned addr;
    int unsigned pix;
    int unsigned cyc;
    bit          bsy;
  } wr_rec_t;

  wr_rec_t     wq[$];
  int unsigned dq[$];
  int unsigned cyc;
  int          n_checks;
  int          n_fail;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && we) wq.push_back('{addr: 32'(addr_w), pix: 32'(pixel_in), cyc: cyc, bsy: busy});
    if (reset_n && done) dq.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wq.delete();
    dq.delete();
  endtask

  // Starts from a negedge; returns right after the posedge that takes the word.
  task automatic wait_accept(input string tag);
    logic r;
    bit   ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      #1 r = wr_ready;
      @(posedge clk);
      if (r) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok) $display("[tb] %s: word accepted addr=0x%0h data=0x%08h cyc=%0d", tag, wr_addr, wr_data, cyc);
    else check_eq({tag, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic send_word(input string tag, input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wait_accept(tag);
  endtask

  task automatic wait_quiet(input string tag);
    int q;
    bit ok;
    q  = 0;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) q++;
      else q = 0;
      if (q >= 3) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq({tag, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic expect_word(input string tag, input int idx, input int unsigned base, input logic [31:0] d);
    for (int k = 0; k < 16; k++) begin
      if (idx + k < wq.size()) begin
        check_eq({tag, "_addr"}, wq[idx+k].addr, base + 32'(k));
        check_eq({tag, "_pix"}, wq[idx+k].pix, 32'(d[2*k +: 2]));
        if (k > 0) check_eq({tag, "_cyc"}, wq[idx+k].cyc, wq[idx+k-1].cyc + 1);
      end
    end
  endtask

  task automatic expect_fill(input string tag, input int idx, input int unsigned base, input int unsigned code);
    for (int k = 0; k < 256; k++) begin
      if (idx + k < wq.size()) begin
        check_eq({tag, "_addr"}, wq[idx+k].addr, base + 32'(k));
        check_eq({tag, "_pix"}, wq[idx+k].pix, code);
        check_eq({tag, "_busy"}, 32'(wq[idx+k].bsy), 32'd1);
        if (k > 0) check_eq({tag, "_cyc"}, wq[idx+k].cyc, wq[idx+k-1].cyc + 1);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    clr_req  = 1'b0;
    clr_sid  = '0;
    clr_code = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_we", 32'(we), 32'd0);
    check_eq("rst_addr", 32'(addr_w), 32'd0);
    check_eq("rst_pix", 32'(pixel_in), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    #1 check_eq("rst_ready", 32'(wr_ready), 32'd1);
    $display("[tb] reset released");

    // Single word: pixels 0,1,2,3 repeating at 0x050..0x05F
    clear_log();
    send_word("single", 6'd5, 32'hE4E4_E4E4);
    @(negedge clk) wr_valid = 1'b0;
    wait_quiet("single");
    check_eq("single_count", wq.size(), 32'd16);
    expect_word("single", 0, 32'h050, 32'hE4E4_E4E4);
    if (wq.size() >= 4) check_eq("single_pix3", wq[3].pix, 32'd3);
    check_eq("single_done_count", dq.size(), 32'd1);
    if (dq.size() >= 1 && wq.size() >= 16) check_eq("single_done_cyc", dq[0], wq[15].cyc + 1);

    // Back-to-back words with no bubble
    clear_log();
    send_word("b2b0", 6'd0, 32'h1B1B_1B1B);
    send_word("b2b1", 6'd1, 32'hFFFF_0000);
    @(negedge clk) wr_valid = 1'b0;
    wait_quiet("b2b");
    check_eq("b2b_count", wq.size(), 32'd32);
    expect_word("b2b0", 0, 32'h000, 32'h1B1B_1B1B);
    expect_word("b2b1", 16, 32'h010, 32'hFFFF_0000);
    if (wq.size() >= 32) check_eq("b2b_span", wq[31].cyc - wq[0].cyc, 32'd31);
    check_eq("b2b_done_count", dq.size(), 32'd2);
    if (dq.size() >= 2 && wq.size() >= 32) begin
      check_eq("b2b_done0_cyc", dq[0], wq[15].cyc + 1);
      check_eq("b2b_done1_cyc", dq[1], wq[31].cyc + 1);
    end

    // Fill slot 2 with code 2
    clear_log();
    @(negedge clk);
    clr_req  = 1'b1;
    clr_sid  = 2'd2;
    clr_code = 2'b10;
    @(negedge clk) clr_req = 1'b0;
    $display("[tb] fill requested sid=2 code=2");
    wait_quiet("fill");
    check_eq("fill_count", wq.size(), 32'd256);
    expect_fill("fill", 0, 32'h200, 32'd2);
    check_eq("fill_done_count", dq.size(), 32'd1);

    // Collision: fill takes priority; the word follows the fill
    clear_log();
    @(negedge clk);
    clr_req  = 1'b1;
    clr_sid  = 2'd1;
    clr_code = 2'b01;
    wr_valid = 1'b1;
    wr_addr  = 6'd3;
    wr_data  = 32'h0123_4567;
    #1 check_eq("coll_ready", 32'(wr_ready), 32'd0);
    @(negedge clk) clr_req = 1'b0;
    $display("[tb] collision fill sid=1 code=1 with word addr=3");
    wait_accept("coll");
    @(negedge clk) wr_valid = 1'b0;
    wait_quiet("coll");
    check_eq("coll_count", wq.size(), 32'd272);
    expect_fill("coll_fill", 0, 32'h100, 32'd1);
    expect_word("coll_word", 256, 32'h030, 32'h0123_4567);

    // Fill requested mid-word while the next word waits
    clear_log();
    send_word("pend_a", 6'd8, 32'hA5A5_5A5A);
    @(negedge clk);
    wr_addr = 6'd9;
    wr_data = 32'h3C3C_C3C3;
    repeat (7) @(negedge clk);
    clr_req  = 1'b1;
    clr_sid  = 2'd3;
    clr_code = 2'b11;
    @(negedge clk) clr_req = 1'b0;
    $display("[tb] fill queued sid=3 code=3 at shift count 7");
    wait_accept("pend_b");
    @(negedge clk) wr_valid = 1'b0;
    wait_quiet("pend");
    check_eq("pend_count", wq.size(), 32'd288);
    expect_word("pend_a", 0, 32'h080, 32'hA5A5_5A5A);
    expect_fill("pend_fill", 16, 32'h300, 32'd3);
    expect_word("pend_b", 272, 32'h090, 32'h3C3C_C3C3);
    if (wq.size() >= 17) check_eq("pend_no_bubble", wq[16].cyc, wq[15].cyc + 1);
    check_eq("pend_done_count", dq.size(), 32'd3);

    // Reset in the middle of a word
    clear_log();
    send_word("rst_mid", 6'd10, 32'hFFFF_FFFF);
    @(negedge clk) wr_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rstmid_we", 32'(we), 32'd0);
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    check_eq("rstmid_addr", 32'(addr_w), 32'd0);
    $display("[tb] reset asserted at shift count 9");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 check_eq("rstmid_ready", 32'(wr_ready), 32'd1);
    repeat (20) @(negedge clk);
    check_eq("rstmid_writes", wq.size(), 32'd10);
    if (wq.size() >= 10) check_eq("rstmid_last_addr", wq[9].addr, 32'h0A9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_ram_loader.md
SPRITE_RAM_LOADER -- requirements
Module: sprite_ram_loader

Interface
REQ-001 Parameter ADDR, default 10, sprite RAM pixel address width; 2^ADDR pixels of 2 bits each.
REQ-002 Parameter WORD, fixed 32, packed word width; 16 pixels of 2 bits per word.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port wr_valid  input  1  packed-word request valid.
REQ-006 Port wr_ready  output  1  loader accepts a word this cycle.
REQ-007 Port wr_addr  input  ADDR-4  word index; pixel base address = {wr_addr, 4'b0000}.
REQ-008 Port wr_data  input  32  packed pixels; pixel k = wr_data[2k+1:2k], k=0..15.
REQ-009 Port clr_req  input  1  one-cycle pulse: fill one 256-pixel sprite slot.
REQ-010 Port clr_sid  input  ADDR-8  sprite slot to fill; region = {clr_sid, 8'h00}..{clr_sid, 8'hFF}.
REQ-011 Port clr_code  input  2  palette code written by a fill.
REQ-012 Port we  output  1  sprite RAM write strobe.
REQ-013 Port addr_w  output  ADDR  sprite RAM write address.
REQ-014 Port pixel_in  output  2  sprite RAM write data.
REQ-015 Port busy  output  1  high while in SHIFT or FILL.
REQ-016 Port done  output  1  one-cycle pulse on the cycle after the last write of a word or fill.

Function
REQ-017 Three-state FSM: IDLE, SHIFT, FILL.
REQ-018 IDLE: clr_req=1 -> FILL, latch clr_sid/clr_code, pixel counter = 0.
REQ-019 IDLE: clr_req=0, wr_valid=1 -> SHIFT; capture wr_addr and wr_data into holding registers; counter = 0.
REQ-020 clr_req and wr_valid in the same IDLE cycle: fill wins; wr_ready=0 that cycle; word not consumed.
REQ-021 wr_ready = (state==IDLE && !clr_req) || (state==SHIFT && counter==15 && !clr_pending).
REQ-022 Handshake: word transfers only when wr_valid && wr_ready; wr_addr and wr_data are sampled on that edge only.
REQ-023 SHIFT: we=1 every cycle; addr_w = {word_addr, counter[3:0]}; pixel_in = holding[1:0]; holding shifts right by 2 per cycle.
REQ-024 Latency: word accepted on edge T -> writes on cycles T+1..T+16, pixel 0 first, ascending address.
REQ-025 SHIFT, counter==15 with an accepted word: reload holding registers, counter = 0, remain in SHIFT; zero-bubble back-to-back writes; done pulses.
REQ-026 SHIFT, counter==15 without an accepted word: -> IDLE (or FILL if clr_pending); done pulses next cycle.
REQ-027 clr_req outside IDLE: set clr_pending, latch sid/code (a later request overwrites); serviced at the next word boundary before any new word.
REQ-028 FILL: we=1 for 256 consecutive cycles; addr_w = {clr_sid, counter[7:0]}; pixel_in = clr_code; then -> IDLE.
REQ-029 clr_req during FILL: sets clr_pending; serviced immediately after the current fill.
REQ-030 Counter: 8 bits; SHIFT uses [3:0] and ends at 15; FILL ends at 255; no wrap beyond the terminal value.
REQ-031 we, addr_w, pixel_in are registered outputs; they do not depend combinationally on wr_valid/wr_data.
REQ-032 When we=0: addr_w and pixel_in hold their last values.

Reset
REQ-033 reset_n low: state=IDLE; counter=0; holding=0; clr_pending=0.
REQ-034 reset_n low: outputs we=0, addr_w=0, pixel_in=0, busy=0, done=0; wr_ready=1 after release.
REQ-035 Reset mid-SHIFT or mid-FILL aborts immediately; no further writes; RAM contents are the caller's concern.

Structure
REQ-036 Shared sprite package holds: the loader state enum; PIX_PER_WORD=16; SPRITE_PIXELS=256; the 2-bit palette code typedef shared with the sprite source.
REQ-037 Single flat module; no sub-module required.

Verification
REQ-038 Single word: wr_addr=5, wr_data=32'hE4E4_E4E4 -> 16 writes, addr 0x050..0x05F, pixel_in 0,1,2,3 repeating; done one cycle after addr 0x05F.
REQ-039 Back-to-back: words at wr_addr=0 and wr_addr=1 held valid -> 32 consecutive we cycles, addr 0x000..0x01F, no bubble.
REQ-040 Fill: clr_req, clr_sid=2, clr_code=2'b10 -> 256 writes, addr 0x200..0x2FF, all data 2'b10; busy high throughout.
REQ-041 Collision: clr_req and wr_valid in the same IDLE cycle -> fill runs first, wr_ready=0; word accepted after the fill, writes follow.
REQ-042 Pending fill: clr_req at SHIFT counter 7 with another word valid -> the current word completes, the fill runs, then the queued word is written.
REQ-043 Reset: reset_n low at SHIFT counter 9 -> we=0 the same cycle; after release wr_ready=1; no residual writes.
